// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared types for the bit-serial adder/subtractor
//
// Purpose: sequencer state encoding used by serial_addsub.
// Ports:   none (package).

package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_fa.sv
// rtl/serial_addsub_fa.sv - one-bit full adder cell
//
// Purpose: single-bit full adder, the only arithmetic element of serial_addsub.
// Ports:
//   a, b  in   addend bits
//   cin   in   carry in
//   sum   out  a ^ b ^ cin
//   cout  out  majority(a, b, cin)

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, one bit per clock, LSB first
//
// Purpose: captures a, b and sub on start, then pushes one bit pair per cycle
//          through a single full adder cell; pulses done for one cycle when
//          the full WIDTH-bit result, carry-out and signed overflow are ready.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   request, sampled in IDLE or DONE only
//   sub       in   0 = a+b, 1 = a-b (captured with start)
//   a, b      in   WIDTH-bit operands (captured with start)
//   busy      out  high while bits are processed (RUN)
//   done      out  one-cycle pulse, outputs valid from this cycle
//   result    out  WIDTH-bit sum or difference
//   cout      out  final carry; for subtract 1 = no borrow
//   overflow  out  two's-complement overflow

module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              fa_sum;
  logic              fa_cout;
  logic              capture;
  logic              last_bit;

  fa u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // A new operation may only be accepted when nothing is in flight.
  assign capture  = start && (state_q == IDLE || state_q == DONE);
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-value logic
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    if (capture) begin
      // Subtraction is a + ~b + 1: invert b and seed the carry with sub.
      a_sh_d  = a;
      b_sh_d  = b ^ {WIDTH{sub}};
      carry_d = sub;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      // Sum bits enter at the MSB so the word is aligned after WIDTH shifts.
      res_d   = {fa_sum, res_q[WIDTH-1:1]};
      carry_d = fa_cout;
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_bit) begin
        cout_d = fa_cout;
        // Carry into the MSB differs from carry out of it on signed overflow.
        ovf_d  = carry_q ^ fa_cout;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (WIDTH=8 and WIDTH=3)

module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;

  logic       start, sub, busy, done, cout, overflow;
  logic [7:0] a, b, result;

  logic       start3, sub3, busy3, done3, cout3, overflow3;
  logic [2:0] a3, b3, result3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  serial_addsub #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .sub(sub3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .result(result3), .cout(cout3), .overflow(overflow3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {overflow, cout, result}.
  function automatic logic [33:0] model(input int w, input int unsigned ia,
                                        input int unsigned ib, input bit s);
    longint m, ua, ub, sa, sb, r, sr;
    bit c, o;
    logic [31:0] rr;
    m  = longint'(1) << w;
    ua = ia;
    ub = ib;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!s) begin
      r  = ua + ub;
      c  = (r >= m);
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    o  = (sr >= m / 2) || (sr < -(m / 2));
    r  = ((r % m) + m) % m;
    rr = r[31:0];
    return {o, c, rr};
  endfunction

  // Drives one 8-bit operation from the current negedge and checks busy for
  // exactly 8 cycles, then done and results. Ends at the done negedge.
  // inj >= 0 pulses a foreign start on that RUN cycle index.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic is, input int inj);
    logic [33:0] e;
    e = model(8, ia, ib, is);
    start = 1'b1; a = ia; b = ib; sub = is;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      if (k == inj) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      check("busy_run", {31'd0, busy}, 32'd1);
      check("done_run", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("result", {24'd0, result}, {24'd0, e[7:0]});
    check("cout", {31'd0, cout}, {31'd0, e[32]});
    check("overflow", {31'd0, overflow}, {31'd0, e[33]});
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(tag, {30'd0, busy, done}, 32'd0);
    end
  endtask

  initial begin
    logic [33:0] e;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start3 = 1'b0; sub3 = 1'b0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases
    run8(8'h35, 8'h4A, 1'b0, -1);
    check("add_7f_const", {24'd0, result}, 32'h7F);
    idle_check(2, "post_done_idle");
    run8(8'hFF, 8'h01, 1'b0, -1);
    check("ff_plus_1_cout", {31'd0, cout}, 32'd1);
    idle_check(1, "post_done_idle");
    run8(8'h7F, 8'h01, 1'b0, -1);
    check("7f_plus_1_ovf", {31'd0, overflow}, 32'd1);
    idle_check(1, "post_done_idle");
    run8(8'h10, 8'h20, 1'b1, -1);
    check("sub_borrow_res", {24'd0, result}, 32'hF0);
    idle_check(1, "post_done_idle");
    run8(8'h80, 8'h01, 1'b1, -1);
    check("sub_ovf", {31'd0, overflow}, 32'd1);
    idle_check(1, "post_done_idle");

    // Start while busy is ignored; only one done pulse follows
    run8(8'h01, 8'h02, 1'b0, 2);
    check("ignored_start_res", {24'd0, result}, 32'h03);
    idle_check(10, "single_done");

    // Back-to-back: start in DONE cycle
    run8(8'h12, 8'h34, 1'b0, -1);
    run8(8'hC3, 8'h5A, 1'b1, -1);
    idle_check(1, "b2b_tail");

    // Hold: outputs stay stable in IDLE while inputs wiggle
    e = model(8, 8'hC3, 8'h5A, 1'b1);
    a = 8'h00; b = 8'hFF; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_result", {24'd0, result}, {24'd0, e[7:0]});

    // Reset on RUN cycle 4
    start = 1'b1; a = 8'h66; b = 8'h77; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", {24'd0, result}, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    idle_check(12, "no_done_after_rst");

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), -1);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
    idle_check(1, "rand_tail");

    // Exhaustive WIDTH=3, back-to-back
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      e = model(3, v[5:3], v[2:0], v[6]);
      start3 = 1'b1; sub3 = v[6]; a3 = v[5:3]; b3 = v[2:0];
      @(negedge clk);
      start3 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check("w3_busy", {30'd0, busy3, done3}, 32'd2);
        @(negedge clk);
      end
      check("w3_done", {30'd0, busy3, done3}, 32'd1);
      check("w3_result", {29'd0, result3}, {29'd0, e[2:0]});
      check("w3_cout", {31'd0, cout3}, {31'd0, e[32]});
      check("w3_ovf", {31'd0, overflow3}, {31'd0, e[33]});
    end
    @(negedge clk);
    check("w3_tail", {30'd0, busy3, done3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor: accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first, through a single one-bit full adder cell.
- Reports result, carry-out and signed overflow with a one-cycle done pulse.
- Low-area arithmetic engine for control paths where latency is cheap and gates are not.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  WIDTH  operand A, captured with start.
- b  input  WIDTH  operand B, captured with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result/cout/overflow valid from this cycle.
- result  output  WIDTH  sum or difference.
- cout  output  1  final carry; for subtract, 1 = no borrow.
- overflow  output  1  signed (two's-complement) overflow.

Behaviour:
- Clocking: single clock. rst is sampled on the rising edge, synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0, bit counter=0, carry register=0.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: counter==WIDTH-1 -> DONE.
  - DONE: lasts one cycle; start=1 -> RUN, else IDLE.
- Start capture (IDLE or DONE, start=1):
  - A-shift <= a; B-shift <= b XOR {WIDTH{sub}}; carry <= sub.
  - counter <= 0; sub latched internally.
- RUN, each edge:
  - Full adder cell input a = A-shift[0], input b = B-shift[0], input cin = carry.
  - Sum bit shifts into result from the MSB side (right shift), so after WIDTH bits result holds the full word.
  - carry <= cell cout. A-shift and B-shift shift right. counter increments.
- Last bit (counter==WIDTH-1):
  - cout <= cell cout.
  - overflow <= cell cin XOR cell cout, i.e. carry into MSB XOR carry out of MSB.
  - State -> DONE.
- Latency: start sampled at edge E0; done=1 in the cycle following edge E_WIDTH, i.e. done is visible WIDTH cycles after the start edge.
- busy: 1 exactly in RUN (WIDTH cycles).
- done: 1 exactly in DONE; never two consecutive cycles unless back-to-back starts produce separate DONE states.
- Output holding:
  - result/cout/overflow are held stable from DONE until the next captured start.
  - During RUN, result is intermediate and not valid.
- start while busy: ignored; operands are not recaptured and the operation in flight completes unaffected.
- Back-to-back: start=1 in the DONE cycle is accepted; RUN restarts on the next edge; done still pulses for the prior operation.
- sub/a/b changes outside the capture cycle have no effect.
- Reset mid-operation: next edge forces IDLE and all reset values; no done pulse for the aborted operation.
- Reset has priority over start on the same edge.
- Arithmetic: all modulo 2^WIDTH.
  - Add: {cout,result} = a+b.
  - Subtract: result = a + ~b + 1; cout = (a >= b unsigned).

Decomposition:
- Package serial_addsub_pkg holds:
  - state enum typedef (IDLE, RUN, DONE), 2 bits.
  - localparam CNT_W = $clog2(WIDTH), computed in the module because it depends on WIDTH.
- One sub-module: instantiate the codebase's existing one-bit full adder cell `fa` (a, b, cin, sum, cout) as the single arithmetic element.
- No other hierarchy.

Test Plan:
- Add, WIDTH=8: a=0x35, b=0x4A, sub=0 -> done 8 cycles after the start edge; result=0x7F, cout=0, overflow=0; busy high for exactly 8 cycles.
- Add with carry and overflow, two runs:
  - 0xFF+0x01 -> result=0x00, cout=1, overflow=0.
  - 0x7F+0x01 -> result=0x80, cout=0, overflow=1.
- Subtract, two runs:
  - 0x10-0x20 -> result=0xF0, cout=0 (borrow), overflow=0.
  - 0x80-0x01 -> result=0x7F, cout=1, overflow=1.
- Protocol, start ignored while busy:
  - Start 0x01+0x02, then pulse start with 0xAA/0x55 on cycle 3 of RUN -> done result=0x03, one done pulse only.
  - Assert start in the DONE cycle -> second operation runs; its done arrives 8 cycles later.
- Reset mid-operation: assert rst on cycle 4 of RUN -> next cycle busy=0, done=0, result=0, cout=0, overflow=0; no done pulse afterward until a new start.
- Exhaustive, WIDTH=3: all 8x8 operand pairs x sub in {0,1} (128 operations) back-to-back -> result/cout/overflow match a behavioural model every done pulse.
